// File: rtl/matrix_coproc_ctrl.sv
// matrix_coproc_ctrl: PIO command sequencer for the 5x5 signed int8 matrix ALU.
// Loads operand rows and scalar, launches the ALU, captures result, returns rows.

module matrix_coproc_ctrl #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int ROWS           = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [2:0]             i_cmd_op,
    input  logic [2:0]             i_cmd_row,
    input  logic [8*ROWS-1:0]      i_cmd_data,
    input  logic [1:0]             i_cmd_alu_op,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ack,
    output logic [8*ROWS-1:0]      o_rsp_data,
    output logic                   o_rsp_ovf,
    output logic                   o_rsp_err,
    output logic [8*ROWS*ROWS-1:0] o_mat_a,
    output logic [8*ROWS*ROWS-1:0] o_mat_b,
    output logic [7:0]             o_esc,
    output logic [1:0]             o_alu_op,
    output logic                   o_alu_en,
    input  logic [8*ROWS*ROWS-1:0] i_alu_result,
    input  logic                   i_alu_ovf,
    input  logic                   i_alu_done
);

    localparam int RW = 8 * ROWS;
    localparam int MW = RW * ROWS;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    ROW_LIM  = 3'(ROWS);

    localparam logic [2:0] OP_LOAD_A  = 3'b000;
    localparam logic [2:0] OP_LOAD_B  = 3'b001;
    localparam logic [2:0] OP_SET_ESC = 3'b010;
    localparam logic [2:0] OP_EXEC    = 3'b011;
    localparam logic [2:0] OP_READ    = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_CAPTURE,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [MW-1:0] r_mat_a;
    logic [MW-1:0] r_mat_b;
    logic [MW-1:0] r_res;
    logic [7:0]    r_esc;
    logic [1:0]    r_alu_op;
    logic          r_alu_en;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic          r_rsp_ovf;
    logic [RW-1:0] r_rsp_data;
    logic [CW-1:0] r_cnt;

    logic          w_row_ok;
    logic [RW-1:0] w_rd_row;
    logic          w_ld_a;
    logic          w_ld_b;
    logic          w_ld_esc;
    logic          w_rd;
    logic          w_exec;
    logic          w_cap;
    logic          w_err;
    logic          w_ack;
    logic          w_tick;

    assign w_row_ok = (i_cmd_row < ROW_LIM);

    // Select the result row addressed by the current command
    always_comb begin
        w_rd_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (i_cmd_row == 3'(r)) begin
                w_rd_row = r_res[RW*r +: RW];
            end
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_ld_a      = 1'b0;
        w_ld_b      = 1'b0;
        w_ld_esc    = 1'b0;
        w_rd        = 1'b0;
        w_exec      = 1'b0;
        w_cap       = 1'b0;
        w_err       = 1'b0;
        w_ack       = 1'b0;
        w_tick      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    w_state_nxt = S_RESP;
                    unique case (i_cmd_op)
                        OP_LOAD_A: begin
                            w_ld_a = w_row_ok;
                            w_err  = !w_row_ok;
                        end
                        OP_LOAD_B: begin
                            w_ld_b = w_row_ok;
                            w_err  = !w_row_ok;
                        end
                        OP_SET_ESC: begin
                            w_ld_esc = 1'b1;
                        end
                        OP_EXEC: begin
                            w_exec      = 1'b1;
                            w_state_nxt = S_RUN;
                        end
                        OP_READ: begin
                            w_rd  = w_row_ok;
                            w_err = !w_row_ok;
                        end
                        default: begin
                            w_err = 1'b1;
                        end
                    endcase
                end
            end
            S_RUN: begin
                if (i_alu_done) begin
                    w_state_nxt = S_CAPTURE;
                end else if (r_cnt == TMO_LAST) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_tick = 1'b1;
                end
            end
            S_CAPTURE: begin
                w_cap       = 1'b1;
                w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!i_alu_done) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (i_rsp_ack) begin
                    w_ack       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand, result and response registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mat_a     <= '0;
            r_mat_b     <= '0;
            r_res       <= '0;
            r_esc       <= '0;
            r_alu_op    <= '0;
            r_alu_en    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_ovf   <= 1'b0;
            r_rsp_data  <= '0;
            r_cnt       <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                if (w_ld_a && (i_cmd_row == 3'(r))) begin
                    r_mat_a[RW*r +: RW] <= i_cmd_data;
                end
                if (w_ld_b && (i_cmd_row == 3'(r))) begin
                    r_mat_b[RW*r +: RW] <= i_cmd_data;
                end
            end
            if (w_ld_esc) begin
                r_esc <= i_cmd_data[7:0];
            end
            if (w_exec) begin
                r_alu_op <= i_cmd_alu_op;
                r_cnt    <= '0;
            end else if (w_tick) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_cap) begin
                r_res     <= i_alu_result;
                r_rsp_ovf <= i_alu_ovf;
            end
            // ALU enable spans RUN plus the capture cycle
            r_alu_en    <= (w_state_nxt == S_RUN) ||
                           (w_state_nxt == S_CAPTURE);
            r_rsp_valid <= (w_state_nxt == S_RESP);
            if (w_ack) begin
                r_rsp_err  <= 1'b0;
                r_rsp_data <= '0;
            end else begin
                if (w_err) begin
                    r_rsp_err <= 1'b1;
                end
                if (w_rd) begin
                    r_rsp_data <= w_rd_row;
                end
            end
        end
    end

    assign o_cmd_ready = (r_state == S_IDLE);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_ovf   = r_rsp_ovf;
    assign o_rsp_err   = r_rsp_err;
    assign o_mat_a     = r_mat_a;
    assign o_mat_b     = r_mat_b;
    assign o_esc       = r_esc;
    assign o_alu_op    = r_alu_op;
    assign o_alu_en    = r_alu_en;

endmodule

// File: tb/tb_matrix_coproc_ctrl.sv
// tb_matrix_coproc_ctrl: directed bench with a matrix-level reference model.
// The bench also plays the ALU, driving result, overflow and done.

module tb_matrix_coproc_ctrl;

    localparam int TMO = 1023;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_cmd_valid = 1'b0;
    logic         o_cmd_ready;
    logic [2:0]   i_cmd_op = '0;
    logic [2:0]   i_cmd_row = '0;
    logic [39:0]  i_cmd_data = '0;
    logic [1:0]   i_cmd_alu_op = '0;
    logic         o_rsp_valid;
    logic         i_rsp_ack = 1'b0;
    logic [39:0]  o_rsp_data;
    logic         o_rsp_ovf;
    logic         o_rsp_err;
    logic [199:0] o_mat_a;
    logic [199:0] o_mat_b;
    logic [7:0]   o_esc;
    logic [1:0]   o_alu_op;
    logic         o_alu_en;
    logic [199:0] i_alu_result = '0;
    logic         i_alu_ovf = 1'b0;
    logic         i_alu_done = 1'b0;

    always #5 clk = ~clk;

    matrix_coproc_ctrl #(
        .TIMEOUT_CYCLES(TMO),
        .ROWS(5)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_op    (i_cmd_op),
        .i_cmd_row   (i_cmd_row),
        .i_cmd_data  (i_cmd_data),
        .i_cmd_alu_op(i_cmd_alu_op),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ack   (i_rsp_ack),
        .o_rsp_data  (o_rsp_data),
        .o_rsp_ovf   (o_rsp_ovf),
        .o_rsp_err   (o_rsp_err),
        .o_mat_a     (o_mat_a),
        .o_mat_b     (o_mat_b),
        .o_esc       (o_esc),
        .o_alu_op    (o_alu_op),
        .o_alu_en    (o_alu_en),
        .i_alu_result(i_alu_result),
        .i_alu_ovf   (i_alu_ovf),
        .i_alu_done  (i_alu_done)
    );

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [199:0] m_a;
    logic [199:0] m_b;
    logic [199:0] m_res;
    logic [7:0]   m_esc;
    logic         m_ovf;
    logic [1:0]   m_aop;
    logic [39:0]  m_data;
    logic         m_err;
    bit           m_busy;

    task automatic chk(input string nm, input logic [199:0] act,
                       input logic [199:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int el(input logic [199:0] m, input int r, input int c);
        return int'($signed(m[40*r+8*c +: 8]));
    endfunction

    // Matrix-level ALU reference: wrap to int8, flag any out-of-range element
    task automatic alu_model(input logic [1:0] op, output logic [199:0] res,
                             output logic ov);
        int v;
        res = '0;
        ov  = 1'b0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                case (op)
                    2'd0: v = el(m_a, r, c) + el(m_b, r, c);
                    2'd1: v = el(m_a, r, c) - el(m_b, r, c);
                    2'd2: v = int'($signed(m_esc)) * el(m_a, r, c);
                    default: begin
                        v = 0;
                        for (int k = 0; k < 5; k++) begin
                            v += el(m_a, r, k) * el(m_b, k, c);
                        end
                    end
                endcase
                if (v > 127 || v < -128) ov = 1'b1;
                res[40*r+8*c +: 8] = 8'(v);
            end
        end
    endtask

    task automatic reset_model();
        m_a    = '0;
        m_b    = '0;
        m_res  = '0;
        m_esc  = '0;
        m_ovf  = 1'b0;
        m_aop  = '0;
        m_data = '0;
        m_err  = 1'b0;
        m_busy = 1'b0;
    endtask

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mat_a", o_mat_a, m_a);
            chk("mat_b", o_mat_b, m_b);
            chk("esc", 200'(o_esc), 200'(m_esc));
            chk("alu_op", 200'(o_alu_op), 200'(m_aop));
            chk("cmd_ready", 200'(o_cmd_ready), 200'(!m_busy));
            if (o_rsp_valid) begin
                chk("rsp_data", 200'(o_rsp_data), 200'(m_data));
                chk("rsp_err", 200'(o_rsp_err), 200'(m_err));
                chk("rsp_ovf", 200'(o_rsp_ovf), 200'(m_ovf));
            end
        end
    end

    task automatic send_cmd(input logic [2:0] op, input logic [2:0] row,
                            input logic [39:0] data, input logic [1:0] aop);
        int ri;
        @(negedge clk);
        i_cmd_valid  = 1'b1;
        i_cmd_op     = op;
        i_cmd_row    = row;
        i_cmd_data   = data;
        i_cmd_alu_op = aop;
        for (int w = 0; w < 50 && !o_cmd_ready; w++) @(negedge clk);
        chk("accept_ready", 200'(o_cmd_ready), 200'(1));
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
        ri = int'(row);
        m_busy = 1'b1;
        m_data = '0;
        m_err  = 1'b0;
        case (op)
            3'b000: if (ri < 5) m_a[40*ri +: 40] = data; else m_err = 1'b1;
            3'b001: if (ri < 5) m_b[40*ri +: 40] = data; else m_err = 1'b1;
            3'b010: m_esc = data[7:0];
            3'b011: m_aop = aop;
            3'b100: if (ri < 5) m_data = m_res[40*ri +: 40]; else m_err = 1'b1;
            default: m_err = 1'b1;
        endcase
    endtask

    task automatic ack_resp();
        i_rsp_ack = 1'b1;
        @(posedge clk);
        #1;
        i_rsp_ack = 1'b0;
        m_busy = 1'b0;
        @(negedge clk);
        chk("ack_valid", 200'(o_rsp_valid), 200'(0));
        chk("ack_err", 200'(o_rsp_err), 200'(0));
        chk("ack_data", 200'(o_rsp_data), 200'(0));
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [2:0] row,
                           input logic [39:0] data);
        send_cmd(op, row, data, 2'b00);
        @(negedge clk);
        chk("lat1_valid", 200'(o_rsp_valid), 200'(1));
        ack_resp();
    endtask

    task automatic read_row(input logic [2:0] row, input logic [39:0] exp);
        send_cmd(3'b100, row, 40'h0, 2'b00);
        @(negedge clk);
        chk("rd_valid", 200'(o_rsp_valid), 200'(1));
        chk("rd_literal", 200'(o_rsp_data), 200'(exp));
        ack_resp();
    endtask

    // Launch EXEC; leaves the response pending for the caller
    task automatic do_exec(input logic [1:0] op, input int dly, input bit stall);
        logic [199:0] r;
        logic         ov;
        int           n;
        alu_model(op, r, ov);
        send_cmd(3'b011, 3'd0, 40'h0, op);
        m_err = stall;
        n = 0;
        if (stall) begin
            for (int i = 0; i < TMO + 20; i++) begin
                @(negedge clk);
                if (o_rsp_valid) break;
                n++;
            end
            chk("tmo_valid", 200'(o_rsp_valid), 200'(1));
            chki("tmo_cycles", n, TMO);
            chk("tmo_alu_en", 200'(o_alu_en), 200'(0));
        end else begin
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                chk("run_alu_en", 200'(o_alu_en), 200'(1));
            end
            i_alu_result = r;
            i_alu_ovf    = ov;
            i_alu_done   = 1'b1;
            m_res = r;
            m_ovf = ov;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                n++;
                if (o_rsp_valid) break;
                if (!o_alu_en) i_alu_done = 1'b0;
            end
            chk("exec_valid", 200'(o_rsp_valid), 200'(1));
            chki("done_to_valid", n, 3);
        end
    endtask

    initial begin
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", 200'(o_cmd_ready), 200'(1));
        chk("rst_valid", 200'(o_rsp_valid), 200'(0));
        chk("rst_alu_en", 200'(o_alu_en), 200'(0));
        chk("rst_mat_a", o_mat_a, 200'(0));

        // Stray ack in IDLE does nothing
        i_rsp_ack = 1'b1;
        @(posedge clk);
        #1;
        i_rsp_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_valid", 200'(o_rsp_valid), 200'(0));
        chk("stray_ack_ready", 200'(o_cmd_ready), 200'(1));

        // Add: each element of A plus one
        for (int r = 0; r < 5; r++) begin
            run_cmd(3'b000, 3'(r), 40'h0102030405);
            run_cmd(3'b001, 3'(r), 40'h0101010101);
        end
        do_exec(2'b00, 2, 1'b0);
        chk("add_err", 200'(o_rsp_err), 200'(0));
        chk("add_ovf", 200'(o_rsp_ovf), 200'(0));
        ack_resp();
        read_row(3'd2, 40'h0203040506);

        // Scalar multiply with one overflowing element
        run_cmd(3'b010, 3'd0, 40'h0000000003);
        run_cmd(3'b000, 3'd0, 40'h0000000040);
        do_exec(2'b10, 1, 1'b0);
        chk("smul_ovf", 200'(o_rsp_ovf), 200'(1));
        ack_resp();
        read_row(3'd0, 40'h00000000C0);
        for (int r = 1; r < 5; r++) read_row(3'(r), 40'h0306090C0F);

        // Bad row and illegal opcode leave registers alone
        run_cmd(3'b000, 3'd5, 40'hFFFFFFFFFF);
        run_cmd(3'b111, 3'd0, 40'hFFFFFFFFFF);
        read_row(3'd7, 40'h0);
        chk("mat_a_kept", o_mat_a,
            {{4{40'h0102030405}}, 40'h0000000040});

        // Timeout: ALU never finishes; old result and flag survive
        do_exec(2'b01, 0, 1'b1);
        chk("tmo_err", 200'(o_rsp_err), 200'(1));
        ack_resp();
        chk("tmo_ovf_kept", 200'(o_rsp_ovf), 200'(1));
        read_row(3'd0, 40'h00000000C0);

        // Command held through an unacknowledged response
        send_cmd(3'b010, 3'd0, 40'h0000000055, 2'b00);
        i_cmd_valid = 1'b1;
        i_cmd_data  = 40'h0000000066;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", 200'(o_rsp_valid), 200'(1));
            chk("hold_ready", 200'(o_cmd_ready), 200'(0));
        end
        i_cmd_valid = 1'b0;
        ack_resp();
        chk("hold_esc", 200'(o_esc), 200'(8'h55));

        // Identity times B returns B
        for (int r = 0; r < 5; r++) begin
            run_cmd(3'b000, 3'(r), 40'h1 << (8 * r));
        end
        run_cmd(3'b001, 3'd0, 40'h807F01FF10);
        run_cmd(3'b001, 3'd1, 40'h1122334455);
        run_cmd(3'b001, 3'd2, 40'hF0E0D0C0B0);
        run_cmd(3'b001, 3'd3, 40'h0000000000);
        run_cmd(3'b001, 3'd4, 40'h7F807F8001);
        do_exec(2'b11, 4, 1'b0);
        chk("mmul_ovf", 200'(o_rsp_ovf), 200'(0));
        ack_resp();
        read_row(3'd0, 40'h807F01FF10);
        read_row(3'd1, 40'h1122334455);
        read_row(3'd2, 40'hF0E0D0C0B0);
        read_row(3'd3, 40'h0000000000);
        read_row(3'd4, 40'h7F807F8001);

        // Reset in the middle of RUN
        send_cmd(3'b011, 3'd0, 40'h0, 2'b01);
        chk_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_en", 200'(o_alu_en), 200'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();
        chk_en = 1'b1;
        @(negedge clk);
        chk("mid_rst_en", 200'(o_alu_en), 200'(0));
        chk("mid_rst_valid", 200'(o_rsp_valid), 200'(0));
        chk("mid_rst_err", 200'(o_rsp_err), 200'(0));
        chk("mid_rst_ovf", 200'(o_rsp_ovf), 200'(0));
        chk("mid_rst_data", 200'(o_rsp_data), 200'(0));
        chk("mid_rst_mat_a", o_mat_a, 200'(0));
        chk("mid_rst_mat_b", o_mat_b, 200'(0));
        chk("mid_rst_esc", 200'(o_esc), 200'(0));
        chk("mid_rst_op", 200'(o_alu_op), 200'(0));
        chk("mid_rst_ready", 200'(o_cmd_ready), 200'(1));
        read_row(3'd1, 40'h0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
